// File: rtl/hist_pkg.sv
// Shared definitions for the histogram read-side sweep engine.
package hist_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int BIN_W_DEF  = 16;
    localparam int SUM_W_DEF  = 24;
    localparam int NUM_BINS   = 256;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/hist_rd_fifo.sv
// Small synchronous FIFO holding {bin, count} pairs returned by the histogram memory.
// Head is read combinationally so the output stage can load it in the same cycle.
module hist_rd_fifo #(
    parameter  int DEPTH = 3,
    parameter  int W     = 24,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH (not a power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/histogram_reader.sv
// Sweeps all histogram bins through the calculator read port and streams
// {bin, count, cdf} beats over valid/ready, capturing peak bin and frame total.
// Handshake: a beat transfers on a cycle where m_valid & m_ready are both high;
// once m_valid rises, m_* hold stable until that transfer.
module histogram_reader
    import hist_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SUM_W  = SUM_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              hist_rd_en,
    output logic [ADDR_W-1:0] hist_addr,
    input  logic [BIN_W-1:0]  hist_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_bin,
    output logic [BIN_W-1:0]  m_count,
    output logic [SUM_W-1:0]  m_cdf,
    output logic              m_last,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [BIN_W-1:0]  peak_count,
    output logic [SUM_W-1:0]  total,
    output logic [1:0]        fsm_state
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_BIN = '1;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                busy_q, done_q;
    logic [SUM_W-1:0]    acc_q;
    logic [ADDR_W-1:0]   run_bin_q;
    logic [BIN_W-1:0]    run_cnt_q;
    logic [ADDR_W-1:0]   peak_bin_q;
    logic [BIN_W-1:0]    peak_cnt_q;
    logic [SUM_W-1:0]    total_q;
    logic [CW-1:0]       inflight_q;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [ADDR_W-1:0]   bin_pipe [RD_LAT];
    logic                m_valid_q, m_last_q;
    logic [ADDR_W-1:0]   m_bin_q;
    logic [BIN_W-1:0]    m_count_q;
    logic [SUM_W-1:0]    m_cdf_q;

    logic                      rd_en, hs, load, cap_valid, head_vld, new_peak;
    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]             fifo_cnt;
    logic [ADDR_W+BIN_W-1:0]   fifo_head;
    logic [ADDR_W-1:0]         head_bin;
    logic [BIN_W-1:0]          head_cnt;
    logic [SUM_W-1:0]          cdf_base;

    // Credit check, handshake and FIFO bypass steering.
    always_comb begin
        rd_en     = (state_q == ST_SWEEP) &&
                    (({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CW + 1)'(DEPTH));
        hs        = m_valid_q && m_ready;
        load      = !m_valid_q || m_ready;
        cap_valid = vld_pipe[RD_LAT-1];
        fifo_pop  = load && !fifo_empty;
        // Returning data skips the FIFO when it is empty and the output stage is free.
        fifo_push = cap_valid && !(load && fifo_empty) && !fifo_full;
        head_vld  = !fifo_empty || cap_valid;
        head_bin  = fifo_empty ? bin_pipe[RD_LAT-1] : fifo_head[ADDR_W+BIN_W-1:BIN_W];
        head_cnt  = fifo_empty ? hist_data : fifo_head[BIN_W-1:0];
        // A beat loaded on the same edge as a handshake chains off the beat leaving.
        cdf_base  = hs ? m_cdf_q : acc_q;
        new_peak  = m_count_q > run_cnt_q;
    end

    // Sweep FSM with issue address, CDF accumulator, running peak and result commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_q      <= '0;
            run_bin_q  <= '0;
            run_cnt_q  <= '0;
            peak_bin_q <= '0;
            peak_cnt_q <= '0;
            total_q    <= '0;
        end else begin
            if (hs) begin
                acc_q <= m_cdf_q;
                if (new_peak) begin
                    run_bin_q <= m_bin_q;
                    run_cnt_q <= m_count_q;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    addr_q    <= '0;
                    acc_q     <= '0;
                    run_bin_q <= '0;
                    run_cnt_q <= '0;
                    if (start) begin
                        state_q <= ST_SWEEP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (rd_en) begin
                        addr_q <= addr_q + 1'b1;
                        if (addr_q == LAST_BIN) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (hs && m_last_q) begin
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        total_q    <= m_cdf_q;
                        peak_bin_q <= new_peak ? m_bin_q : run_bin_q;
                        peak_cnt_q <= new_peak ? m_count_q : run_cnt_q;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-return tracking: which bin lands on hist_data, and reads still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe   <= '0;
            inflight_q <= '0;
            for (int i = 0; i < RD_LAT; i++) bin_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            bin_pipe[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                bin_pipe[i] <= bin_pipe[i-1];
            end
            case ({rd_en, cap_valid})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Registered output stage, refilled whenever it is empty or its beat is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            m_bin_q   <= '0;
            m_count_q <= '0;
            m_cdf_q   <= '0;
            m_last_q  <= 1'b0;
        end else if (load) begin
            if (head_vld) begin
                m_valid_q <= 1'b1;
                m_bin_q   <= head_bin;
                m_count_q <= head_cnt;
                m_cdf_q   <= cdf_base + SUM_W'(head_cnt);
                m_last_q  <= (head_bin == LAST_BIN);
            end else begin
                m_valid_q <= 1'b0;
            end
        end
    end

    hist_rd_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + BIN_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({bin_pipe[RD_LAT-1], hist_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign hist_rd_en = rd_en;
    assign hist_addr  = addr_q;
    assign m_valid    = m_valid_q;
    assign m_bin      = m_bin_q;
    assign m_count    = m_count_q;
    assign m_cdf      = m_cdf_q;
    assign m_last     = m_last_q;
    assign peak_bin   = peak_bin_q;
    assign peak_count = peak_cnt_q;
    assign total      = total_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_histogram_reader.sv
// Directed bench for histogram_reader with a latency-2 histogram memory model.
module tb_histogram_reader;

  localparam int LAT   = 2;
  localparam int DEPTH = LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] hist_data;
  logic        busy, done, hist_rd_en, m_valid, m_last;
  logic [7:0]  hist_addr, m_bin, peak_bin;
  logic [15:0] m_count, peak_count;
  logic [23:0] m_cdf, total;
  logic [1:0]  fsm_state;

  histogram_reader #(.BIN_W(16), .ADDR_W(8), .SUM_W(24), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .hist_rd_en(hist_rd_en), .hist_addr(hist_addr), .hist_data(hist_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_bin(m_bin), .m_count(m_count),
    .m_cdf(m_cdf), .m_last(m_last), .peak_bin(peak_bin), .peak_count(peak_count),
    .total(total), .fsm_state(fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // histogram memory model: data for address issued in cycle t appears in cycle t+LAT
  logic [15:0] mem [256];
  logic [15:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= mem[hist_addr];
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign hist_data = dpipe[LAT-1];

  // scoreboard state
  int total_n = 0;
  int bad_n = 0;
  int done_cnt = 0;
  int exp_dones = 0;
  int duty = 100;
  logic [48:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // m_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1 m_ready = ($urandom_range(0, 99) < duty);
    end
  end

  always @(posedge clk) if (rst && done) done_cnt++;

  // stream monitor: order, stability, credit bound, no reissue
  logic [48:0] held;
  bit          hold_prev = 0;
  int          issued = 0;
  int          accepted = 0;
  logic [7:0]  exp_addr = 8'd0;
  logic [48:0] exp_beat;
  always @(negedge clk) begin
    if (!rst) begin
      issued = 0; accepted = 0; exp_addr = 8'd0; hold_prev = 0;
    end else begin
      if (hist_rd_en) begin
        check("credit", (issued - accepted - int'(m_valid)) < DEPTH, 1'b1);
        check("issue_addr", hist_addr, exp_addr);
        issued++;
        exp_addr++;
      end
      if (hold_prev) check("stable", {m_bin, m_count, m_cdf, m_last}, held);
      if (m_valid && m_ready) begin
        check("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_beat = exp_q.pop_front();
          check("beat", {m_bin, m_count, m_cdf, m_last}, exp_beat);
        end
        accepted++;
      end
      hold_prev = m_valid && !m_ready;
      held = {m_bin, m_count, m_cdf, m_last};
    end
  end

  // stimulus table
  typedef struct {
    int          pat;
    int          duty;
    bit          timed;
    bit          poke;
    logic [23:0] tot;
    logic [7:0]  pk_bin;
    logic [15:0] pk_cnt;
  } vec_t;
  vec_t vecs[7];

  task automatic fill_mem(input int pat);
    for (int k = 0; k < 256; k++) begin
      case (pat)
        0: mem[k] = 16'd1;
        1: mem[k] = 16'(k);
        2: mem[k] = 16'hFFFF;
        3: mem[k] = 16'd0;
        4: mem[k] = (k == 37 || k == 200) ? 16'd5 : 16'd0;
        default: mem[k] = 16'(255 - k);
      endcase
    end
  endtask

  task automatic build_exp();
    logic [23:0] cdf;
    cdf = 24'd0;
    exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      cdf = cdf + 24'(mem[k]);
      exp_q.push_back({8'(k), mem[k], cdf, (k == 255)});
    end
  endtask

  task automatic run_sweep(input vec_t v);
    int start_cyc, first_cyc, last_cyc, done_cyc;
    bit got_done, early, ok;
    logic [47:0] prev;
    fill_mem(v.pat);
    build_exp();
    duty = v.duty;
    prev = {peak_bin, peak_count, total};
    early = 0; got_done = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    @(posedge clk);
    #1 start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_c1", busy, 1'b1);
    check("rd_en_c1", hist_rd_en, 1'b1);
    check("addr_c1", hist_addr, 8'd0);
    for (int n = 0; n < 5000; n++) begin
      if (done) begin
        got_done = 1;
        done_cyc = cyc - start_cyc;
        break;
      end
      if (m_valid && first_cyc < 0) first_cyc = cyc - start_cyc;
      if (m_valid && m_last && last_cyc < 0) last_cyc = cyc - start_cyc;
      if ({peak_bin, peak_count, total} !== prev) early = 1;
      start = (v.poke && busy && n == 60);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", got_done, 1'b1);
    if (got_done) exp_dones++;
    check("busy_in_done", busy, 1'b0);
    check("all_beats", exp_q.size(), 0);
    check("results_stable", early, 1'b0);
    check("total", total, v.tot);
    check("peak_bin", peak_bin, v.pk_bin);
    check("peak_count", peak_count, v.pk_cnt);
    if (v.timed) begin
      check("first_beat_cyc", first_cyc, 2 + LAT);
      check("last_beat_cyc", last_cyc, 257 + LAT);
      check("done_cyc", done_cyc, 258 + LAT);
    end
    if (v.poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1;
      for (int n = 0; n < 20; n++) begin
        if (busy || done) ok = 0;
        @(negedge clk);
      end
      check("no_restart", ok, 1'b1);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_en"}, hist_rd_en, 1'b0);
    check({tag, "_addr"}, hist_addr, 8'd0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_beat"}, {m_bin, m_count, m_cdf, m_last}, 49'd0);
    check({tag, "_peak"}, {peak_bin, peak_count}, 24'd0);
    check({tag, "_total"}, total, 24'd0);
    check({tag, "_state"}, fsm_state, 2'd0);
  endtask

  // main sequence
  initial begin
    bit found;
    vecs[0] = '{pat: 0, duty: 100, timed: 1, poke: 0, tot: 24'd256,      pk_bin: 8'd0,   pk_cnt: 16'd1};
    vecs[1] = '{pat: 0, duty: 100, timed: 1, poke: 0, tot: 24'd256,      pk_bin: 8'd0,   pk_cnt: 16'd1};
    vecs[2] = '{pat: 1, duty: 30,  timed: 0, poke: 0, tot: 24'd32640,    pk_bin: 8'd255, pk_cnt: 16'd255};
    vecs[3] = '{pat: 2, duty: 100, timed: 1, poke: 1, tot: 24'd16776960, pk_bin: 8'd0,   pk_cnt: 16'hFFFF};
    vecs[4] = '{pat: 3, duty: 50,  timed: 0, poke: 0, tot: 24'd0,        pk_bin: 8'd0,   pk_cnt: 16'd0};
    vecs[5] = '{pat: 4, duty: 70,  timed: 0, poke: 0, tot: 24'd10,       pk_bin: 8'd37,  pk_cnt: 16'd5};
    vecs[6] = '{pat: 5, duty: 30,  timed: 0, poke: 0, tot: 24'd32640,    pk_bin: 8'd0,   pk_cnt: 16'd255};
    fill_mem(0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_sweep(vecs[i]);

    // reset mid-sweep at bin 100
    fill_mem(0);
    build_exp();
    duty = 100;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (m_valid && m_bin == 8'd100) begin
        found = 1;
        break;
      end
    end
    check("reach_bin100", found, 1'b1);
    rst = 1'b0;
    #1 check_zero("async_rst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_sweep(vecs[0]);

    repeat (3) @(negedge clk);
    check("done_count", done_cnt, exp_dones);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/histogram_reader.md
# histogram_reader

Sweep engine for the read side of `histogram_calculator`. On a `start` pulse it reads all 256 bins through the calculator's read port (`external_addr_rd` / `external_data_rd`) and streams them out over a valid/ready interface.

- Each beat carries bin index, bin count and cumulative count (CDF).
- Also captures the peak bin and the frame total, for the equalisation LUT builder and the MicroBlaze register bank.

## Interface
Parameters:
- `BIN_W` = 16: width of one histogram bin.
- `ADDR_W` = 8: bin address width; the block always sweeps 2^ADDR_W bins.
- `SUM_W` = 24: CDF/total width. Must be ≥ BIN_W+ADDR_W; no overflow is possible.
- `RD_LAT` = 1: fixed read latency of the histogram memory, in clocks (1..3).

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a sweep. Ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `hist_rd_en`  out  1  read issued this cycle.
- `hist_addr`  out  ADDR_W  bin address; connects to `external_addr_rd`.
- `hist_data`  in  BIN_W  bin count, valid RD_LAT cycles after issue.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_bin`  out  ADDR_W  bin index of the beat.
- `m_count`  out  BIN_W  bin count.
- `m_cdf`  out  SUM_W  running sum of bins 0..m_bin inclusive.
- `m_last`  out  1  beat for bin 255.
- `peak_bin`  out  ADDR_W  bin with the highest count in the last completed sweep.
- `peak_count`  out  BIN_W  that count.
- `total`  out  SUM_W  sum of all bins in the last completed sweep.

## Operation
- **Reset values:** all outputs 0, FSM in IDLE, FIFO empty.
- **IDLE:**
  - `start` → SWEEP.
  - Clears the issue address, CDF accumulator and running peak.
  - `peak_*` and `total` keep their last values.
- **SWEEP:**
  - Issues a read (`hist_rd_en`=1, `hist_addr`=next address) whenever credits > 0.
  - credits = FIFO depth − (reads in flight + FIFO occupancy).
  - After address 255 is issued → DRAIN.
- **DRAIN:** stays until the beat with `m_last` is accepted (`m_valid & m_ready & m_last`) → DONE.
- **DONE:**
  - Lasts one cycle: `done`=1, `busy`=0 in the same cycle.
  - Commits `peak_*` and `total`, then → IDLE.
- **Return data:**
  - Read data plus bin index is captured RD_LAT cycles after issue into a FIFO of depth RD_LAT+2.
  - The FIFO can never overflow, by construction of the credit count.
- **Output stage:**
  - Registered from the FIFO head.
  - `m_cdf` = previous CDF + `m_count`.
  - The accumulator updates only on handshake.
- **Peak tracking:** updates only when count > running peak (strict), so ties keep the lowest bin. An all-zero histogram gives peak_bin=0, peak_count=0.
- **Output stability:** `m_*` holds stable while `m_valid & !m_ready`.
- **Reset mid-sweep:** aborts immediately. Outputs return to reset values, including `peak_*` and `total`.
- **`start` in DONE cycle:** ignored.

## Timing
- `start` sampled at cycle 0. `busy` and the first `hist_rd_en` (addr 0) occur in cycle 1.
- With `m_ready` held high:
  - bin k is on `m_*` in cycle 2+RD_LAT+k, one beat per cycle, no bubbles;
  - `m_last` in cycle 257+RD_LAT;
  - `done` in cycle 258+RD_LAT.
- With `m_ready` low:
  - issue stalls once credits reach 0;
  - at most RD_LAT+2 beats are outstanding;
  - no read is ever reissued.
- `peak_*` and `total` change only in the DONE cycle.

## Structure
- Shared package `hist_pkg`: ADDR_W/BIN_W/SUM_W defaults, NUM_BINS=256, FSM state encoding (IDLE, SWEEP, DRAIN, DONE).
- One sub-module, `hist_rd_fifo`: synchronous FIFO with parameter DEPTH, carrying {bin, count}, with full/empty/count outputs.
- The FSM, credit counter, CDF and peak logic live in the top module.

## Test plan
- **Ramp frame:** `histogram_calculator` fed one 16×16 frame where pixel = {row[3:0], col[3:0]}; `m_ready`=1.
  - Every `m_count`=1 and `m_cdf`=k+1.
  - `total`=256, peak_bin=0 (tie rule).
  - `done` in cycle 258+RD_LAT.
- **Backpressure:** memory model with RD_LAT=2, bin k = k; random `m_ready` at 30% duty.
  - Beats stay in order with no loss or duplication.
  - `hist_rd_en` never fires when credits = 0.
  - `total`=32640, peak_bin=255.
- **Saturation-width check:** all bins 0xFFFF.
  - Final `m_cdf` = `total` = 16776960.
  - peak_bin=0.
- **Start handling:**
  - `start` pulsed during SWEEP and during DONE → no restart and exactly one `done`.
  - `start` one cycle after `done` → second sweep with identical output.
- **Reset mid-sweep:** `rst` low at bin 100.
  - All outputs 0 asynchronously; FIFO empty.
  - A new `start` produces a full, correct sweep from bin 0.
